// File: rtl/rvfpm_xif_queue_pkg.sv
// Shared types and constants for the rvfpm XIF issue/commit queue.
// Optional statistics outputs are enabled by defining RVFPM_QUEUE_STATS_EN.
package pa_rvfpm;

  localparam int RVFPM_STAT_WIDTH  = 16;
  localparam int RVFPM_X_ID_WIDTH  = 4;
  localparam int RVFPM_INSTR_WIDTH = 32;

  // Entry layout at the default widths; the queue mirrors it at its own widths.
  typedef struct packed {
    logic [RVFPM_INSTR_WIDTH-1:0] instr;
    logic [RVFPM_X_ID_WIDTH-1:0]  id;
    logic                         committed;
    logic                         killed;
    logic                         valid;
  } rvfpm_q_entry_t;

  function automatic logic [RVFPM_STAT_WIDTH-1:0] stat_sat_inc(
    input logic [RVFPM_STAT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rvfpm_xif_queue_id_match.sv
// Compares a commit ID against every valid queue entry and returns the
// oldest hit as a one-hot vector, searching forward from the read pointer.
module rvfpm_id_match #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4
) (
  input  logic [DEPTH-1:0][X_ID_WIDTH-1:0] ids,
  input  logic [DEPTH-1:0]                 valid,
  input  logic [X_ID_WIDTH-1:0]            commit_id,
  input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
  output logic [DEPTH-1:0]                 match_oh
);

  localparam int PW = $clog2(DEPTH);

  logic           found;
  logic [PW-1:0]  idx;

  always_comb begin
    match_oh = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (!found && valid[idx] && (ids[idx] == commit_id)) begin
        match_oh[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfpm_xif_queue.sv
// In-order issue/commit tracking queue: dispatches committed, non-killed
// instructions to the FPU. Statistics ports exist when RVFPM_QUEUE_STATS_EN is defined.
module rvfpm_xif_queue
  import pa_rvfpm::*;
#(
  parameter int DEPTH       = 4,
  parameter int X_ID_WIDTH  = 4,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                         ck,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         issue_accept,
  input  logic [INSTR_WIDTH-1:0]       issue_instr,
  input  logic [X_ID_WIDTH-1:0]        issue_id,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [INSTR_WIDTH-1:0]       disp_instr,
  output logic [X_ID_WIDTH-1:0]        disp_id,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
`ifdef RVFPM_QUEUE_STATS_EN
  ,
  output logic [RVFPM_STAT_WIDTH-1:0]  stat_killed,
  output logic [RVFPM_STAT_WIDTH-1:0]  stat_full_stall,
  output logic [$clog2(DEPTH+1)-1:0]   stat_max_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [X_ID_WIDTH-1:0]  id;
    logic                   committed;
    logic                   killed;
    logic                   valid;
  } q_entry_t;

  q_entry_t                         q [DEPTH];
  logic [PW-1:0]                    rd_ptr, wr_ptr;
  logic [CW-1:0]                    count_q;
  q_entry_t                         head;
  logic [DEPTH-1:0][X_ID_WIDTH-1:0] entry_ids;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0]                 match_oh;
  logic                             push, pop, commit_en, push_commit, kill_pop;

  always_comb begin
    entry_ids   = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_ids[i]   = q[i].id;
      entry_valid[i] = q[i].valid;
    end
  end

  rvfpm_id_match #(.DEPTH(DEPTH), .X_ID_WIDTH(X_ID_WIDTH)) u_id_match (
    .ids       (entry_ids),
    .valid     (entry_valid),
    .commit_id (commit_id),
    .rd_ptr    (rd_ptr),
    .match_oh  (match_oh)
  );

  // Handshakes (issue, disp): a transfer happens on a rising ck edge where
  // valid && ready; valid never depends on ready, ready never on valid.
  assign head        = q[rd_ptr];
  assign issue_ready = (count_q != CW'(DEPTH)) && !flush;
  assign push        = issue_valid && issue_ready && issue_accept;
  assign commit_en   = commit_valid && !flush;
  // A same-cycle commit lands on the new entry only if no older entry holds the ID.
  assign push_commit = commit_en && push && (issue_id == commit_id) && !(|match_oh);
  assign kill_pop    = head.valid && head.committed && head.killed;
  assign disp_valid  = head.valid && head.committed && !head.killed;
  assign pop         = !flush && (kill_pop || (disp_valid && disp_ready));

  assign disp_instr  = head.instr;
  assign disp_id     = head.id;
  assign count       = count_q;
  assign empty       = (count_q == '0);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid     <= 1'b0;
        q[i].committed <= 1'b0;
        q[i].killed    <= 1'b0;
      end
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_en && match_oh[i]) begin
          q[i].committed <= 1'b1;
          q[i].killed    <= commit_kill;
        end
      end
      if (pop) begin
        q[rd_ptr].valid <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (push) begin
        q[wr_ptr] <= '{instr: issue_instr, id: issue_id, committed: push_commit,
                       killed: push_commit && commit_kill, valid: 1'b1};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef RVFPM_QUEUE_STATS_EN
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      stat_killed     <= '0;
      stat_full_stall <= '0;
      stat_max_count  <= '0;
    end else begin
      if (pop && kill_pop)            stat_killed     <= stat_sat_inc(stat_killed);
      if (issue_valid && !issue_ready) stat_full_stall <= stat_sat_inc(stat_full_stall);
      if (count_q > stat_max_count)   stat_max_count  <= count_q;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

`ifndef SYNTHESIS
  commit_known_a: assert property (@(posedge ck) disable iff (!rst_n)
    (commit_valid && !flush) |-> ((|match_oh) || (push && (issue_id == commit_id))));
`endif

endmodule

// File: tb/tb_rvfpm_xif_queue.sv
// Scoreboard bench for rvfpm_xif_queue at DEPTH = 4; stats checks compile in
// when RVFPM_QUEUE_STATS_EN is defined.
module tb_rvfpm_xif_queue;
  import pa_rvfpm::*;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = IDW + IW;

  logic            ck, rst_n, flush;
  logic            issue_valid, issue_ready, issue_accept;
  logic [IW-1:0]   issue_instr;
  logic [IDW-1:0]  issue_id;
  logic            commit_valid, commit_kill;
  logic [IDW-1:0]  commit_id;
  logic            disp_valid, disp_ready;
  logic [IW-1:0]   disp_instr;
  logic [IDW-1:0]  disp_id;
  logic [CW-1:0]   count;
  logic            empty;
`ifdef RVFPM_QUEUE_STATS_EN
  logic [RVFPM_STAT_WIDTH-1:0] stat_killed, stat_full_stall;
  logic [CW-1:0]               stat_max_count;
`endif

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  rvfpm_xif_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .INSTR_WIDTH(IW)) dut (
    .ck           (ck),
    .rst_n        (rst_n),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_accept (issue_accept),
    .issue_instr  (issue_instr),
    .issue_id     (issue_id),
    .commit_valid (commit_valid),
    .commit_id    (commit_id),
    .commit_kill  (commit_kill),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_instr   (disp_instr),
    .disp_id      (disp_id),
    .count        (count),
    .empty        (empty)
`ifdef RVFPM_QUEUE_STATS_EN
    ,
    .stat_killed     (stat_killed),
    .stat_full_stall (stat_full_stall),
    .stat_max_count  (stat_max_count)
`endif
  );

  // Clock / reset
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  // Scoreboard: every dispatch handshake pops the oldest expected {id, instr}
  always @(negedge ck) begin
    logic [W-1:0] exp;
    if (rst_n && !flush && disp_valid && disp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_unexpected: got id=%0d instr=%h, expected no dispatch", disp_id, disp_instr);
      end else begin
        exp = exp_q.pop_front();
        if ({disp_id, disp_instr} !== exp) begin
          errors++;
          $display("FAIL disp_order: got id=%0d instr=%h, expected id=%0d instr=%h",
                   disp_id, disp_instr, exp[W-1:IW], exp[IW-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic clear_inputs();
    flush        = 1'b0;
    issue_valid  = 1'b0;
    issue_accept = 1'b1;
    issue_instr  = '0;
    issue_id     = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
  endtask

  task automatic drive_issue(input logic [IDW-1:0] id, input logic [IW-1:0] instr);
    issue_valid  = 1'b1;
    issue_accept = 1'b1;
    issue_id     = id;
    issue_instr  = instr;
  endtask

  task automatic drive_commit(input logic [IDW-1:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    int n = 0;
    while (!empty && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL %s_drain: count=%0d after %0d cycles, required 0", name, count, max_cycles);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    disp_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    checks++; if (disp_valid !== 1'b0)  begin errors++; $display("FAIL reset_disp_valid: got %b, required 0", disp_valid); end
    checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b, required 1", issue_ready); end
    checks++; if (count !== '0)         begin errors++; $display("FAIL reset_count: got %0d, required 0", count); end
    checks++; if (disp_id !== '0 || disp_instr !== '0) begin
      errors++; $display("FAIL reset_disp_data: got id=%0d instr=%h, required 0/0", disp_id, disp_instr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_accept_drop();
    drive_issue(4'd9, 32'h1234_5678);
    issue_accept = 1'b0;
    tick();
    clear_inputs();
    checks++; if (count !== '0) begin errors++; $display("FAIL accept_drop_count: got %0d, required 0", count); end
  endtask

  task automatic test_issue_commit();
    disp_ready = 1'b1;
    drive_issue(4'd3, 32'h0010_7053);
    drive_commit(4'd3, 1'b0);
    exp_q.push_back({4'd3, 32'h0010_7053});
    tick();
    clear_inputs();
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL ic_disp_valid: got %b, required 1", disp_valid); end
    checks++; if (disp_id !== 4'd3)    begin errors++; $display("FAIL ic_disp_id: got %0d, required 3", disp_id); end
    checks++; if (count !== 3'd1)      begin errors++; $display("FAIL ic_count: got %0d, required 1", count); end
    tick();
    checks++; if (count !== '0 || empty !== 1'b1) begin
      errors++; $display("FAIL ic_drained: got count=%0d empty=%b, required 0/1", count, empty);
    end
  endtask

  task automatic test_full();
`ifdef RVFPM_QUEUE_STATS_EN
    logic [RVFPM_STAT_WIDTH-1:0] stall0;
`endif
    disp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_issue(4'(i), 32'hA000_0000 + i);
      exp_q.push_back({4'(i), 32'hA000_0000 + i});
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (count !== 3'd4)       begin errors++; $display("FAIL full_count: got %0d, required 4", count); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_issue_ready: got %b, required 0", issue_ready); end
`ifdef RVFPM_QUEUE_STATS_EN
    stall0 = stat_full_stall;
`endif
    drive_issue(4'd5, 32'hBAD0_0005);
    repeat (3) tick();
    clear_inputs();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_stalled_count: got %0d, required 4", count); end
`ifdef RVFPM_QUEUE_STATS_EN
    checks++; if (stat_full_stall !== stall0 + 16'd3) begin
      errors++; $display("FAIL stat_full_stall: got %0d, required %0d", stat_full_stall, stall0 + 16'd3);
    end
`endif
    disp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_commit(4'(i), 1'b0);
      tick();
    end
    clear_inputs();
    wait_empty("full", 20);
  endtask

  task automatic test_commit_order();
    disp_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_issue(4'(i), 32'hC000_0000 + i);
      exp_q.push_back({4'(i), 32'hC000_0000 + i});
      tick();
    end
    clear_inputs();
    drive_commit(4'd3, 1'b0);
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL order_wait3: disp_valid=%b, required 0", disp_valid); end
    drive_commit(4'd2, 1'b0);
    tick();
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL order_wait2: disp_valid=%b, required 0", disp_valid); end
    drive_commit(4'd1, 1'b0);
    tick();
    clear_inputs();
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (disp_valid !== 1'b1 || disp_id !== 4'(i)) begin
        errors++; $display("FAIL order_seq%0d: got valid=%b id=%0d, required 1/%0d", i, disp_valid, disp_id, i);
      end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b, required 1", empty); end
  endtask

  task automatic test_kill();
    disp_ready = 1'b1;
    drive_issue(4'd5, 32'hD000_0005);
    tick();
    drive_issue(4'd6, 32'hD000_0006);
    exp_q.push_back({4'd6, 32'hD000_0006});
    tick();
    clear_inputs();
    drive_commit(4'd5, 1'b1);
    tick();
    checks++; if (disp_valid !== 1'b0 || count !== 3'd2) begin
      errors++; $display("FAIL kill_silent: got valid=%b count=%0d, required 0/2", disp_valid, count);
    end
    drive_commit(4'd6, 1'b0);
    tick();
    clear_inputs();
    checks++; if (disp_valid !== 1'b1 || disp_id !== 4'd6 || count !== 3'd1) begin
      errors++; $display("FAIL kill_next: got valid=%b id=%0d count=%0d, required 1/6/1", disp_valid, disp_id, count);
    end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL kill_empty: got %b, required 1", empty); end
`ifdef RVFPM_QUEUE_STATS_EN
    checks++; if (stat_killed !== 16'd1) begin errors++; $display("FAIL stat_killed: got %0d, required 1", stat_killed); end
`endif
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    logic [IW-1:0] instr;
    for (int cyc = 0; cyc < 200 && sent < 10; cyc++) begin
      disp_ready = (cyc % 2 == 0);
      #0;
      if (issue_ready) begin
        instr = $urandom_range(32'hFFFF_FFFF, 0);
        drive_issue(4'(sent), instr);
        drive_commit(4'(sent), 1'b0);
        exp_q.push_back({4'(sent), instr});
        sent++;
      end else begin
        clear_inputs();
      end
      tick();
      checks++;
      if (count > 3'd4) begin errors++; $display("FAIL b2b_count: got %0d, required <= 4", count); end
    end
    clear_inputs();
    checks++; if (sent != 10) begin errors++; $display("FAIL b2b_sent: got %0d issues, required 10", sent); end
    disp_ready = 1'b1;
    wait_empty("b2b", 20);
  endtask

  task automatic test_flush_reset();
    disp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_issue(4'(i), 32'hE000_0000 + i);
      tick();
    end
    clear_inputs();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d, required 3", count); end
    flush = 1'b1;
    drive_issue(4'd4, 32'hE000_0004);
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_issue_ready: got %b, required 0", issue_ready); end
    tick();
    clear_inputs();
    checks++; if (empty !== 1'b1 || count !== '0) begin
      errors++; $display("FAIL flush_empty: got empty=%b count=%0d, required 1/0", empty, count);
    end
    drive_issue(4'd7, 32'hE000_0007);
    drive_commit(4'd7, 1'b0);
    tick();
    clear_inputs();
    checks++; if (disp_valid !== 1'b1 || disp_id !== 4'd7) begin
      errors++; $display("FAIL pre_reset_disp: got valid=%b id=%0d, required 1/7", disp_valid, disp_id);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (disp_valid !== 1'b0 || issue_ready !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL async_reset: got valid=%b ready=%b empty=%b, required 0/1/1", disp_valid, issue_ready, empty);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_accept_drop();
    test_issue_commit();
    test_full();
    test_commit_order();
    test_kill();
    test_back_to_back();
    test_flush_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d expected dispatches never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvfpm_xif_queue.md
Name: rvfpm_xif_queue

Overview:
- Pure-RTL issue/commit tracking queue for the rvfpm coprocessor on the CORE-V-XIF.
- Holds instructions accepted on the issue interface and marks them committed or killed as commit transactions arrive.
- Dispatches only committed, non-killed instructions, in order, to the FPU execute pipeline.
- Successor to the fixed, model-side queue: depth and widths are parametrised, and it adds commit/kill filtering, flush and backpressure.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- X_ID_WIDTH, 4, XIF instruction ID width.
- INSTR_WIDTH, 32, instruction word width.

Ports:
- ck  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- issue_valid  in  1  XIF issue request valid.
- issue_ready  out  1  queue can accept an issue.
- issue_accept  in  1  predecoder accept for the current issue request.
- issue_instr  in  INSTR_WIDTH  issued instruction.
- issue_id  in  X_ID_WIDTH  issued ID.
- commit_valid  in  1  XIF commit valid.
- commit_id  in  X_ID_WIDTH  committed ID.
- commit_kill  in  1  kill the instruction with commit_id.
- disp_valid  out  1  head entry ready for execute.
- disp_ready  in  1  execute accepts the head entry.
- disp_instr  out  INSTR_WIDTH  head instruction.
- disp_id  out  X_ID_WIDTH  head ID.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entry valid/committed/killed flags cleared; rd_ptr = wr_ptr = 0; count = 0.
  - Outputs: disp_valid = 0, empty = 1, issue_ready = 1, disp_instr/disp_id = 0.
- issue_ready = (count != DEPTH) && !flush.
  - It depends on count only, so a full queue refuses a push even in a cycle where it pops.
- Push:
  - Happens when issue_valid && issue_ready && issue_accept.
  - Entry written at wr_ptr with committed = 0, killed = 0; wr_ptr increments modulo DEPTH.
  - A handshake with issue_accept = 0 is consumed and nothing is stored.
- Commit:
  - On commit_valid, commit_id is compared against all valid entries.
  - On a match, the oldest matching entry gets committed = 1 and killed = commit_kill.
  - A commit in the same cycle as the push of the same ID applies to the newly pushed entry.
  - A commit with no match is dropped; the simulation assertion fires only if commit_id is not in flight and not being pushed.
- Head handling (head = entry at rd_ptr):
  - Head valid, committed, killed: popped silently in one cycle; disp_valid stays 0.
  - Head valid, committed, not killed: disp_valid = 1 and disp_instr/disp_id driven from head flops. Pop on disp_ready.
  - Head uncommitted: disp_valid = 0. Dispatch is strictly in order; younger committed entries wait.
- Latency: issue and commit in cycle N give disp_valid = 1 in cycle N+1. Maximum throughput is one dispatch per cycle.
- Pop: rd_ptr increments modulo DEPTH.
- count: +1 on push, -1 on pop, unchanged on simultaneous push and pop.
- flush:
  - In the cycle it is high, the next state is empty, with pointers and count at 0.
  - A concurrent push or commit is dropped. disp_valid is still combinational from head, but no pop occurs.
- Pointer wrap: pointers are $clog2(DEPTH) bits; full and empty are distinguished by count.

Optional Feature:
- Macro: RVFPM_QUEUE_STATS_EN.
- With it defined, three extra outputs are present:
  - stat_killed, 16 bit, saturating: silent pops of killed entries.
  - stat_full_stall, 16 bit, saturating: cycles with issue_valid && !issue_ready.
  - stat_max_count, $clog2(DEPTH+1) bit: high-water mark.
- All three reset asynchronously to 0 and are unaffected by flush.
- Without the macro, the ports and logic are absent.

Decomposition:
- Package pa_rvfpm gains:
  - typedef rvfpm_q_entry_t {instr, id, committed, killed, valid}.
  - RVFPM_STAT_WIDTH = 16.
- Sub-module rvfpm_id_match: combinational compare of commit_id against DEPTH entries. Outputs a one-hot oldest-match vector, rotated from rd_ptr.

Test Plan:
- Issue ID 3 instr 0x00107053 with commit (kill = 0) in the same cycle, disp_ready = 1 -> disp_valid = 1 next cycle, disp_id = 3, then count returns to 0.
- Issue IDs 1, 2, 3, 4 without commit (DEPTH = 4) -> issue_ready = 0 and count = 4. A fifth issue_valid is stalled; with stats, stat_full_stall increments each stall cycle.
- Fill IDs 1 to 3, commit 3 then 2 then 1 -> nothing dispatches until ID 1 commits, then IDs 1, 2, 3 dispatch on consecutive cycles.
- Issue IDs 5, 6, kill 5, commit 6 -> ID 5 is popped silently with disp_valid = 0, ID 6 dispatches one cycle later, stat_killed = 1.
- Push/pop across wrap: 10 back-to-back committed issues with disp_ready toggling 1/0 -> dispatch order 0 to 9 is preserved and count never exceeds 4.
- flush with 3 entries plus a concurrent issue, then rst_n low mid-dispatch -> empty = 1 next cycle with the issue dropped. Reset immediately forces disp_valid = 0 and issue_ready = 1.
